// File: rtl/me_search_loader.sv
// me_search_loader: double-buffered search-window loader for the ME core.
// A raster pixel stream is scattered into PORT_WIDTH column-interleaved
// banks; the ME core reads one rotated PORT_WIDTH-pixel row slice per address.
// Optional build macro: ME_LOADER_PERF_EN adds a saturating stall counter on
// stall_cycles; without it stall_cycles is tied to zero.
module me_search_loader #(
    parameter  int MACRO_DIM  = 16,
    parameter  int SEARCH_DIM = 48,
    localparam int PORT_WIDTH = MACRO_DIM + 1,
    localparam int SLABS      = (SEARCH_DIM + PORT_WIDTH - 1) / PORT_WIDTH,
    localparam int DEPTH      = SLABS * SEARCH_DIM,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_pixel,
    input  logic              in_sof,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [5:0]        rd_amt,
    output logic [7:0]        pixel_spr_out [0:MACRO_DIM],
    output logic              win_valid,
    output logic              me_start,
    input  logic              win_release,
    output logic [31:0]       stall_cycles
);

    localparam int COL_W      = $clog2(SEARCH_DIM);
    localparam int BANK_W     = $clog2(PORT_WIDTH);
    localparam int WRAP_ITERS = 128 / PORT_WIDTH;

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(SEARCH_DIM - 1);
    localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(PORT_WIDTH - 1);
    localparam logic [ADDR_W-1:0] SLAB_STEP = ADDR_W'(SEARCH_DIM);
    localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);
    localparam logic [6:0]        PW7       = 7'(PORT_WIDTH);

    typedef enum logic [0:0] {LOAD, WAIT_SWAP} state_t;

    state_t              state;
    logic                wr_sel;
    logic                rd_sel;
    logic [COL_W-1:0]    col_cnt;
    logic [COL_W-1:0]    row_cnt;
    logic [BANK_W-1:0]   bank_cnt;
    logic [ADDR_W-1:0]   slab_base;

    logic                accept;
    logic                last_px;
    logic [COL_W-1:0]    cur_col;
    logic [COL_W-1:0]    cur_row;
    logic [BANK_W-1:0]   cur_bank;
    logic [ADDR_W-1:0]   cur_base;
    logic [ADDR_W-1:0]   wr_addr;
    logic [BANK_W-1:0]   amt_mod;

    // Two buffers x PORT_WIDTH banks x DEPTH bytes; never reset.
    logic [7:0] mem [0:1][0:PORT_WIDTH-1][0:DEPTH-1];

    // Reduce a small value modulo PORT_WIDTH by repeated conditional subtraction.
    function automatic logic [BANK_W-1:0] wrap_bank(input logic [6:0] v);
        logic [6:0] t;
        t = v;
        for (int k = 0; k < WRAP_ITERS; k++) begin
            if (t >= PW7) t = t - PW7;
        end
        return t[BANK_W-1:0];
    endfunction

    // Current write position; a start-of-window pixel is forced to (0,0).
    always_comb begin
        accept   = in_valid && in_ready;
        cur_col  = in_sof ? '0 : col_cnt;
        cur_row  = in_sof ? '0 : row_cnt;
        cur_bank = in_sof ? '0 : bank_cnt;
        cur_base = in_sof ? '0 : slab_base;
        wr_addr  = cur_base + ADDR_W'(cur_row);
        last_px  = (cur_col == COL_LAST) && (cur_row == COL_LAST);
    end

    // Scatter accepted pixels into the write buffer.
    always_ff @(posedge clk) begin
        if (accept && !rst) mem[wr_sel][cur_bank][wr_addr] <= in_pixel;
    end

    // Control FSM: raster counters, buffer swap and handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            in_ready  <= 1'b0;
            win_valid <= 1'b0;
            me_start  <= 1'b0;
            wr_sel    <= 1'b0;
            rd_sel    <= 1'b1;
            col_cnt   <= '0;
            row_cnt   <= '0;
            bank_cnt  <= '0;
            slab_base <= '0;
        end else begin
            me_start <= 1'b0;
            if (accept) begin
                if (cur_col == COL_LAST) begin
                    col_cnt   <= '0;
                    bank_cnt  <= '0;
                    slab_base <= '0;
                    row_cnt   <= last_px ? '0 : cur_row + 1'b1;
                end else begin
                    col_cnt <= cur_col + 1'b1;
                    row_cnt <= cur_row;
                    if (cur_bank == BANK_LAST) begin
                        bank_cnt  <= '0;
                        slab_base <= cur_base + SLAB_STEP;
                    end else begin
                        bank_cnt  <= cur_bank + 1'b1;
                        slab_base <= cur_base;
                    end
                end
            end
            case (state)
                LOAD: begin
                    in_ready <= 1'b1;
                    if (accept && last_px) begin
                        if (!win_valid || win_release) begin
                            rd_sel    <= wr_sel;
                            wr_sel    <= ~wr_sel;
                            win_valid <= 1'b1;
                            me_start  <= 1'b1;
                        end else begin
                            state    <= WAIT_SWAP;
                            in_ready <= 1'b0;
                        end
                    end else if (win_release) begin
                        win_valid <= 1'b0;
                    end
                end
                WAIT_SWAP: begin
                    in_ready <= 1'b0;
                    if (win_release) begin
                        rd_sel    <= wr_sel;
                        wr_sel    <= ~wr_sel;
                        win_valid <= 1'b1;
                        me_start  <= 1'b1;
                        in_ready  <= 1'b1;
                        state     <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    // Zero-latency rotated read of one row slice from the read buffer.
    always_comb begin
        amt_mod = wrap_bank({1'b0, rd_amt});
        for (int l = 0; l < PORT_WIDTH; l++) begin
            if (rd_addr < DEPTH_A)
                pixel_spr_out[l] = mem[rd_sel][wrap_bank(7'(l) + 7'(amt_mod))][rd_addr];
            else
                pixel_spr_out[l] = 8'h00;
        end
    end

`ifdef ME_LOADER_PERF_EN
    // Saturating count of stalled cycles (swap wait or refused pixels).
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if ((state == WAIT_SWAP || (in_valid && !in_ready)) &&
                     stall_cycles != 32'hFFFF_FFFF) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_me_search_loader.sv
// Scoreboard bench for me_search_loader: stimulus pushes expected values,
// a negedge monitor pops and compares against the DUT outputs.
module tb_me_search_loader;

    localparam int SD    = 48;
    localparam int PW    = 17;
    localparam int DEPTH = 144;
    localparam int NPIX  = SD * SD;

    localparam int K_PIX   = 0;
    localparam int K_VALID = 1;
    localparam int K_READY = 2;
    localparam int K_START = 3;
    localparam int K_STALL = 4;
    localparam int K_OBS   = 5;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_pixel;
    logic       in_sof;
    logic [7:0] rd_addr;
    logic [5:0] rd_amt;
    logic [7:0] pixel_spr_out [0:16];
    logic       win_valid;
    logic       me_start;
    logic       win_release;
    logic [31:0] stall_cycles;

    me_search_loader dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pixel      (in_pixel),
        .in_sof        (in_sof),
        .rd_addr       (rd_addr),
        .rd_amt        (rd_amt),
        .pixel_spr_out (pixel_spr_out),
        .win_valid     (win_valid),
        .me_start      (me_start),
        .win_release   (win_release),
        .stall_cycles  (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int    kind;
        int    lane;
        int    exp;
        string name;
    } chk_t;

    chk_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: the window being written and the window the ME sees.
    int wr_img [SD][SD];
    int rd_img [SD][SD];
    int mr, mc;
    bit mvalid, mpending;

    task automatic push(input int kind, input int lane, input int exp, input string nm);
        chk_t it;
        it.kind = kind; it.lane = lane; it.exp = exp; it.name = nm;
        sb.push_back(it);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Immediate comparison of a sampled DUT value.
    task automatic check_now(input int act, input int exp, input string nm);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: compare every queued expectation at the falling edge.
    initial begin
        chk_t it;
        int   act;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                it = sb.pop_front();
                case (it.kind)
                    K_PIX:   act = int'(pixel_spr_out[it.lane]);
                    K_VALID: act = int'(win_valid);
                    K_READY: act = int'(in_ready);
                    K_START: act = int'(me_start);
                    K_STALL: act = int'(stall_cycles);
                    default: act = it.lane;
                endcase
                n_cmp++;
                if (act !== it.exp) begin
                    n_bad++;
                    $display("FAIL %s lane=%0d: got %0d, expected %0d", it.name, it.lane, act, it.exp);
                end
            end
        end
    end

    task automatic check_state(input string nm);
        push(K_VALID, 0, int'(mvalid), {nm, "_win_valid"});
        push(K_READY, 0, mpending ? 0 : 1, {nm, "_in_ready"});
    endtask

    // Spec-level model of one accepted pixel; returns whether a swap occurred.
    task automatic model_accept(input int v, input bit sof, input bit rel, output bit swapped);
        bit last;
        swapped = 1'b0;
        if (sof) begin mr = 0; mc = 0; end
        wr_img[mr][mc] = v & 255;
        last = (mr == SD - 1) && (mc == SD - 1);
        mc++;
        if (mc == SD) begin mc = 0; mr = (mr + 1) % SD; end
        if (last) begin
            if (!mvalid || rel) begin
                rd_img   = wr_img;
                mvalid   = 1'b1;
                swapped  = 1'b1;
            end else begin
                mpending = 1'b1;
            end
        end else if (rel) begin
            mvalid = 1'b0;
        end
    endtask

    task automatic send(input int v, input bit sof, input bit rel);
        bit ok;
        bit sw;
        ok = 1'b0;
        in_valid = 1'b1; in_pixel = v[7:0]; in_sof = sof; win_release = rel;
        for (int b = 0; b < 200 && !ok; b++) begin
            if (in_ready) ok = 1'b1;
            tick();
        end
        in_sof = 1'b0; win_release = 1'b0;
        if (!ok) begin
            push(K_OBS, 0, 1, "accept_timeout");
        end else begin
            model_accept(v, sof, rel, sw);
            push(K_START, 0, int'(sw), "me_start_per_accept");
        end
    endtask

    function automatic int pattern(input int idx);
        return idx & 255;
    endfunction

    // Stream pixel indices [first, first+count); mode 0 = ramp, 1 = random.
    task automatic stream(input int first, input int count, input int mode, input bit rel_last);
        int v;
        for (int i = first; i < first + count; i++) begin
            v = (mode == 0) ? pattern(i) : int'($urandom_range(0, 255));
            send(v, 1'b0, rel_last && (i == NPIX - 1));
        end
        in_valid = 1'b0;
    endtask

    task automatic release_pulse(input string nm);
        bit sw;
        sw = 1'b0;
        win_release = 1'b1;
        tick();
        win_release = 1'b0;
        if (mpending) begin
            rd_img = wr_img; mpending = 1'b0; mvalid = 1'b1; sw = 1'b1;
        end else if (mvalid) begin
            mvalid = 1'b0;
        end
        push(K_START, 0, int'(sw), {nm, "_me_start"});
        check_state(nm);
        tick();
    endtask

    task automatic check_read(input int addr, input int amt, input string nm);
        int b, col;
        rd_addr = addr[7:0];
        rd_amt  = amt[5:0];
        for (int l = 0; l < PW; l++) begin
            b = (l + amt) % PW;
            if (addr >= DEPTH) begin
                push(K_PIX, l, 0, {nm, "_oob"});
            end else begin
                col = (addr / SD) * PW + b;
                if (col < SD) push(K_PIX, l, rd_img[addr % SD][col], nm);
            end
        end
        tick();
    endtask

    task automatic random_reads(input int n, input string nm);
        for (int k = 0; k < n; k++)
            check_read(int'($urandom_range(0, 159)), int'($urandom_range(0, 63)), nm);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_pixel = 8'h00; in_sof = 1'b0;
        rd_addr = 8'h00; rd_amt = 6'd0; win_release = 1'b0;
        mr = 0; mc = 0; mvalid = 1'b0; mpending = 1'b0;
        tick(); tick();
        check_now(int'(in_ready), 0, "reset_in_ready_now");
        check_now(int'(win_valid), 0, "reset_win_valid_now");
        push(K_READY, 0, 0, "reset_in_ready");
        push(K_VALID, 0, 0, "reset_win_valid");
        push(K_START, 0, 0, "reset_me_start");
        push(K_STALL, 0, 0, "reset_stall");
        rst = 1'b0;
        tick();
        check_state("post_reset");
        tick();

        // Window 1: ramp pattern from reset, swaps immediately.
        stream(0, NPIX, 0, 1'b0);
        check_state("win1");
        check_read(0, 0, "w1_a0_r0");
        push(K_PIX, 0, 8'h04, "w1_a53_r3_lane0");
        check_read(53, 3, "w1_a53_r3");
        push(K_PIX, 0, 16, "w1_r16_lane0");
        push(K_PIX, 1, 0, "w1_r16_lane1");
        check_read(0, 16, "w1_a0_r16");
        check_read(0, 17, "w1_a0_r17");
        check_read(150, 5, "w1_addr_oob");
        random_reads(20, "w1_rand");

        // Window 2: no release -> stall in WAIT_SWAP.
        stream(0, NPIX, 1, 1'b0);
        check_state("win2_stalled");
        for (int k = 0; k < 20; k++) begin
            if (k % 5 == 0) push(K_READY, 0, 0, "wait_swap_in_ready");
            tick();
            check_now(int'(in_ready), 0, "wait_expired_in_ready");
            check_now(int'(win_valid), 1, "wait_expired_win_valid");
        end
        random_reads(4, "w1_during_stall");
        release_pulse("release_swap");
        random_reads(20, "w2_rand");

        // Window 3: release on the last pixel -> immediate swap.
        stream(0, NPIX, 1, 1'b1);
        check_state("win3_same_cycle_release");
        tick();
        check_state("win3_no_wait_swap");
        random_reads(20, "w3_rand");

        // Release with nothing pending clears win_valid; a second is ignored.
        release_pulse("release_idle");
        release_pulse("release_ignored");

        // Window 4: start-of-window marker on the 101st pixel.
        stream(0, 100, 0, 1'b0);
        send(8'hAA, 1'b1, 1'b0);
        stream(1, NPIX - 1, 0, 1'b0);
        check_state("win4_sof");
        push(K_PIX, 0, 8'hAA, "sof_pixel_00");
        check_read(0, 0, "w4_a0_r0");
        random_reads(10, "w4_rand");

        // Reset mid-load with a valid window.
        stream(0, 1000, 1, 1'b0);
        rst = 1'b1;
        tick();
        push(K_READY, 0, 0, "midrst_in_ready");
        push(K_VALID, 0, 0, "midrst_win_valid");
        push(K_STALL, 0, 0, "midrst_stall");
        rst = 1'b0;
        mr = 0; mc = 0; mvalid = 1'b0; mpending = 1'b0;
        tick();
        check_state("after_midrst");
        stream(0, NPIX, 1, 1'b0);
        check_state("win5_after_rst");
        random_reads(20, "w5_rand");
`ifndef ME_LOADER_PERF_EN
        push(K_STALL, 0, 0, "stall_tied_zero");
`endif
        tick(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/me_search_loader.md
Name: me_search_loader

Overview:
- Upstream feeder for the motion-estimation core.
- Accepts a SEARCH_DIM x SEARCH_DIM search window as a raster pixel stream and scatters it into PORT_WIDTH column-interleaved banks.
- Serves the ME core one rotated PORT_WIDTH-pixel row slice per address.
- Double-buffered: window N+1 loads while the ME consumes window N.

Parameters:
- MACRO_DIM, 16: macroblock edge; PORT_WIDTH = MACRO_DIM+1 (localparam).
- SEARCH_DIM, 48: search window edge in pixels.
- Derived localparams: SLABS = ceil(SEARCH_DIM/PORT_WIDTH) (3); DEPTH = SLABS*SEARCH_DIM (144); ADDR_W = $clog2(DEPTH) (8).

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  pixel present on in_pixel.
- in_ready  out  1  loader can accept a pixel.
- in_pixel  in  8  search pixel, raster order, row-major.
- in_sof  in  1  start-of-window marker, qualified by an accepted pixel.
- rd_addr  in  ADDR_W  read address from the ME core.
- rd_amt  in  6  rotation amount from the ME core.
- pixel_spr_out  out  8 x PORT_WIDTH  array [0:MACRO_DIM] of read pixels.
- win_valid  out  1  read buffer holds a complete window.
- me_start  out  1  one-cycle pulse: new window available to the ME.
- win_release  in  1  ME finished with the read buffer (pulse).

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Storage: two buffers (0/1), each PORT_WIDTH banks x DEPTH bytes.
- Pixel mapping: pixel (row r, col c) goes to bank c%PORT_WIDTH, address (c/PORT_WIDTH)*SEARCH_DIM + r.
  - Bank and slab indices are kept as incremental counters; no dividers.
- Accept rule: a pixel is accepted when in_valid && in_ready.
  - The column counter advances per accepted pixel and wraps at SEARCH_DIM, incrementing the row counter.
- in_sof on an accepted pixel forces that pixel to (0,0) and discards any partial fill of the write buffer.
- FSM states: LOAD, WAIT_SWAP.
  - LOAD: in_ready=1. Accepting pixel (SEARCH_DIM-1, SEARCH_DIM-1) completes the write buffer.
    - If win_valid=0, or win_release is asserted that same cycle: swap. rd_sel<=wr_sel, wr_sel toggles, win_valid<=1, me_start=1 next cycle, stay in LOAD with counters at 0.
    - Otherwise: go to WAIT_SWAP.
  - WAIT_SWAP: in_ready=0. On win_release: swap as above, return to LOAD. in_ready rises the cycle after the swap.
- win_release while in LOAD with no completed window pending: win_valid<=0 next cycle.
- win_release while win_valid=0: ignored.
- Read path: combinational, zero latency. pixel_spr_out[l] = buf[rd_sel].bank[(l+rd_amt)%PORT_WIDTH][rd_addr].
  - rd_amt >= PORT_WIDTH wraps modulo PORT_WIDTH.
  - rd_addr >= DEPTH: output is 0.
  - Output is don't-care while win_valid=0.
- Read and write never target the same buffer, so no read/write collision exists.
- Unwritten bank locations (bank positions beyond SEARCH_DIM in the last slab) hold prior contents. Memories are not cleared on reset.
- Reset values: in_ready=0, win_valid=0, me_start=0, state=LOAD, counters=0, wr_sel=0, rd_sel=1.
  - in_ready=1 from the first cycle after rst deasserts.
  - Reset mid-load or mid-read aborts all windows; the next window must be streamed in full.

Optional Feature:
- ME_LOADER_PERF_EN defined: adds output stall_cycles[31:0].
  - Counts cycles spent in WAIT_SWAP plus cycles with in_valid=1 && in_ready=0.
  - Saturates at 0xFFFFFFFF; cleared by rst.
- Not defined: the port still exists, tied to 0; no counter logic.

Test Plan:
- Stream one window, pixel=(r*48+c)&0xFF, from reset -> win_valid=1 and a single me_start pulse the cycle after the 2304th accept.
  - rd_addr=0, rd_amt=0: pixel_spr_out[l]=l.
  - rd_addr=53, rd_amt=3: pixel_spr_out[0]=(5*48+20)&0xFF=0x04.
- Stream two windows back-to-back with no win_release -> in_ready=0 after the second window's last pixel.
  - Pulse win_release 20 cycles later -> swap, me_start pulses, in_ready=1 the cycle after; reads return window 2 data.
- win_release asserted on the same cycle as the last pixel of window 2 -> win_valid stays 1, me_start pulses, no WAIT_SWAP entry.
- in_sof=1 on accepted pixel 100 with value 0xAA -> that pixel is stored at (0,0).
  - The window completes 2303 accepts later; read rd_addr=0, rd_amt=0 gives pixel_spr_out[0]=0xAA.
- rst pulsed one cycle at accepted pixel 1000 with a window valid -> win_valid=0, in_ready=0 during rst, in_ready=1 after.
  - A full 2304-pixel stream is needed before me_start.
- rd_amt=16, rd_addr=0 on window 1 -> pixel_spr_out[0]=16, pixel_spr_out[1]=0.
  - rd_amt=17 gives the same output as rd_amt=0.
